// File: rtl/uart_xfer_ctrl.sv
// uart_xfer_ctrl: host command sequencer between a UART rx/tx pair and a
// byte-wide buffer memory. LOAD frames stream payload into the buffer from
// address 0 and are answered with ACK_BYTE. DUMP frames read the buffer back
// out through the transmitter. Unknown commands and inter-byte timeouts are
// answered with NAK_BYTE and set the sticky err flag.
module uart_xfer_ctrl #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned TIMEOUT_CYC = 5000000,
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              load_done,
   output logic              err
);

   localparam logic [7:0] CMD_LOAD = 8'h01;
   localparam logic [7:0] CMD_DUMP = 8'h02;

   localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_LOAD,
      S_RD,
      S_RD_WAIT,
      S_TX_REQ,
      S_TX_HOLD,
      S_DONE
   } state_t;

   state_t            r_state;
   logic              r_is_dump;     // current frame is a DUMP
   logic              r_nak;         // pending reply is a NAK: finish straight to IDLE
   logic [7:0]        r_len_hi;
   logic [ADDR_W-1:0] r_cnt;         // bytes still to write (LOAD) or send (DUMP)
   logic [ADDR_W-1:0] r_ptr;
   logic [TMO_W-1:0]  r_tmo;
   logic              r_hold_first;  // first TX_HOLD cycle, tx_busy not yet trustworthy
   logic              r_tx_start;
   logic [7:0]        r_tx_data;
   logic              r_err;

   logic              w_wr;
   logic              w_last;
   logic              w_in_frame;
   logic              w_timeout;
   logic [ADDR_W-1:0] w_len;
   logic              w_cmd_ok;

   // Decode of the current cycle: memory write strobe, frame timeout, length
   always_comb begin
      w_wr       = (r_state == S_LOAD) && rx_valid;
      w_last     = w_wr && (r_cnt == ADDR_W'(1));
      w_in_frame = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_LOAD);
      w_timeout  = w_in_frame && !rx_valid && (r_tmo == TMO_LAST);
      w_len      = ADDR_W'({r_len_hi, rx_data});
      w_cmd_ok   = (rx_data == CMD_LOAD) || (rx_data == CMD_DUMP);
   end

   // Inter-byte timer: restarts on every received byte and outside a frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmo <= '0;
      end else if (!w_in_frame || rx_valid) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + TMO_W'(1);
      end
   end

   // Command sequencer FSM with registered transmitter handshake and flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_is_dump    <= 1'b0;
         r_nak        <= 1'b0;
         r_len_hi     <= '0;
         r_cnt        <= '0;
         r_ptr        <= '0;
         r_hold_first <= 1'b0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
         r_err        <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         if (w_timeout) begin
            // abandon the frame; bytes already written stay in the buffer
            r_err     <= 1'b1;
            r_nak     <= 1'b1;
            r_tx_data <= NAK_BYTE;
            r_state   <= S_TX_REQ;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_ptr <= '0;
                  if (rx_valid && en) begin
                     if (w_cmd_ok) begin
                        r_is_dump <= (rx_data == CMD_DUMP);
                        r_nak     <= 1'b0;
                        r_err     <= 1'b0;
                        r_state   <= S_LEN_HI;
                     end else begin
                        r_is_dump <= 1'b0;
                        r_nak     <= 1'b1;
                        r_err     <= 1'b1;
                        r_tx_data <= NAK_BYTE;
                        r_state   <= S_TX_REQ;
                     end
                  end
               end

               S_LEN_HI: begin
                  if (rx_valid) begin
                     r_len_hi <= rx_data;
                     r_state  <= S_LEN_LO;
                  end
               end

               S_LEN_LO: begin
                  if (rx_valid) begin
                     r_cnt <= w_len;
                     if (w_len == '0) begin
                        if (r_is_dump) begin
                           r_state <= S_DONE;
                        end else begin
                           r_tx_data <= ACK_BYTE;
                           r_state   <= S_TX_REQ;
                        end
                     end else begin
                        r_state <= r_is_dump ? S_RD : S_LOAD;
                     end
                  end
               end

               S_LOAD: begin
                  if (rx_valid) begin
                     r_ptr <= r_ptr + ADDR_W'(1);
                     r_cnt <= r_cnt - ADDR_W'(1);
                     if (r_cnt == ADDR_W'(1)) begin
                        r_tx_data <= ACK_BYTE;
                        r_state   <= S_TX_REQ;
                     end
                  end
               end

               S_RD: begin
                  r_state <= S_RD_WAIT;
               end

               S_RD_WAIT: begin
                  r_tx_data <= mem_rdata;
                  r_state   <= S_TX_REQ;
               end

               S_TX_REQ: begin
                  if (!tx_busy) begin
                     r_tx_start   <= 1'b1;
                     r_hold_first <= 1'b1;
                     r_state      <= S_TX_HOLD;
                  end
               end

               S_TX_HOLD: begin
                  if (r_hold_first) begin
                     r_hold_first <= 1'b0;
                  end else if (!tx_busy) begin
                     if (r_nak) begin
                        r_ptr   <= '0;
                        r_state <= S_IDLE;
                     end else if (r_is_dump && (r_cnt != ADDR_W'(1))) begin
                        r_cnt   <= r_cnt - ADDR_W'(1);
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_state <= S_RD;
                     end else begin
                        r_state <= S_DONE;
                     end
                  end
               end

               S_DONE: begin
                  r_ptr   <= '0;
                  r_state <= S_IDLE;
               end

               default: begin
                  r_ptr   <= '0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Output mapping; the write port is combinational so payload lands with zero latency
   always_comb begin
      tx_start  = r_tx_start;
      tx_data   = r_tx_data;
      busy      = (r_state != S_IDLE);
      err       = r_err;
      mem_wen   = w_wr;
      mem_waddr = r_ptr;
      mem_wdata = w_wr ? rx_data : '0;
      mem_raddr = r_ptr;
      load_done = w_last;
   end

endmodule

// File: doc/uart_xfer_ctrl.md
Name: uart_xfer_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter pair and the byte-wide matrix buffer memory.
- Parses host command frames arriving on the receive byte stream.
- Streams LOAD payloads into buffer memory starting at address 0.
- Reads buffer contents back out through the transmitter on DUMP.
- Owns both memory ports and the transmitter start handshake.

Parameters:
- ADDR_W, 16, buffer address width; lengths and addresses wrap modulo 2^ADDR_W.
- TIMEOUT_CYC, 5000000, cycles allowed between received bytes inside a frame before abort (100 ms at 50 MHz).
- ACK_BYTE, 8'hA5, byte transmitted after a completed LOAD.
- NAK_BYTE, 8'hEE, byte transmitted for an unknown command or a timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  command enable; IDLE ignores rx bytes while low.
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls.
- mem_wen  out  1  buffer write strobe.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- mem_raddr  out  ADDR_W  read address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_raddr is presented.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle pulse when the final LOAD byte is written.
- err  out  1  sticky error flag; cleared on acceptance of the next valid command byte.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters and address pointers 0.
- Frame format: CMD byte, LEN_HI byte, LEN_LO byte, then payload. CMD 8'h01 = LOAD; CMD 8'h02 = DUMP (no payload).
- States: IDLE, LEN_HI, LEN_LO, LOAD, RD, RD_WAIT, TX_REQ, TX_HOLD, DONE.
- IDLE:
  - rx_valid with en=1 and CMD 01 or 02: latch cmd, clear err, go to LEN_HI.
  - Any other CMD byte: set err, queue NAK_BYTE, go to TX_REQ; final return is to IDLE.
  - rx_valid with en=0: byte dropped, no state change.
- LEN_HI: on rx_valid, latch len[15:8], go to LEN_LO.
- LEN_LO: on rx_valid, latch len[7:0]; extra length bits are zero-extended or truncated to ADDR_W.
  - len=0 and LOAD: queue ACK_BYTE, go to TX_REQ.
  - len=0 and DUMP: go to DONE; nothing transmitted.
  - LOAD otherwise: go to LOAD. DUMP otherwise: go to RD.
- LOAD:
  - Each rx_valid: in the same cycle mem_wen=1, mem_waddr=ptr, mem_wdata=rx_data (combinational, zero latency).
  - On the following edge ptr increments and the remaining count decrements.
  - On the last byte, load_done pulses in the write cycle; queue ACK_BYTE; go to TX_REQ.
- RD: drive mem_raddr=ptr; go to RD_WAIT.
- RD_WAIT: register mem_rdata into tx_data; go to TX_REQ.
- TX_REQ: wait until tx_busy=0, then assert tx_start for exactly 1 cycle; go to TX_HOLD.
- TX_HOLD:
  - Ignore tx_busy in the first cycle, since the transmitter may assert it one cycle late.
  - Afterwards wait for tx_busy=0.
  - On release: if DUMP count remains, ptr++ and go to RD; otherwise go to DONE (or IDLE after a NAK).
- DONE: one cycle, then IDLE; ptr resets to 0 on entry to IDLE.
- Timeout:
  - In LEN_HI, LEN_LO and LOAD, a counter reloads on every rx_valid.
  - Reaching TIMEOUT_CYC sets err, queues NAK_BYTE and abandons the frame; bytes already written stay in memory.
- Ignored bytes: rx_valid in any TX or RD state is dropped; the host must wait for the reply.
- Wrap-around: ptr wraps from 2^ADDR_W-1 to 0; len=2^ADDR_W is not representable.
- mem_wen is never asserted outside LOAD.
- Reset asserted mid-frame or mid-transmit: immediate return to reset values. A byte already handed to the transmitter completes on its own.

Test Plan:
- LOAD 3 bytes, frame 01 00 03 11 22 33 -> writes addr0=11, addr1=22, addr2=33; one load_done pulse on the write of 33; one tx_start with tx_data=A5; busy returns to 0.
- After that LOAD, send DUMP frame 02 00 03, transmitter model busy 10 cycles after a one-cycle-late start -> exactly three tx_start pulses carrying 11, 22, 33 in order; no tx_start while tx_busy=1.
- Unknown CMD 7F -> err=1, one tx_start with EE, back in IDLE; then a valid 02 00 00 -> err cleared, no transmission, busy low within 5 cycles.
- LOAD 01 00 04 AA then silence for TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in sim) -> err=1, NAK EE sent, addr0=AA, no load_done pulse.
- With en=0, send 01 -> state stays IDLE, busy=0; raise en, send a full LOAD frame -> normal ACK.
- Assert reset during DUMP with 2 bytes remaining -> all outputs 0 the same cycle, no further tx_start; the next frame is handled normally.
